// File: rtl/controller_rom.sv
// Microprogrammed sequencer for the SAM accumulator CPU: 16 x 40-bit control ROM,
// two condition muxes and a 4:1 next-address mux. Define CTRL_DEBUG_EN to expose state_dbg.
module controller_rom (
  input  logic        clk,
  input  logic        reset,
  input  logic        wait_,
  input  logic        IR15,
  input  logic        IR14,
  input  logic        AC15,
`ifdef CTRL_DEBUG_EN
  output logic [3:0]  state_dbg,
`endif
  output logic [21:0] bus_controller
);

  localparam logic [21:0] C_PC_MAR = 22'h000001;
  localparam logic [21:0] C_IR_MAR = 22'h000002;
  localparam logic [21:0] C_MEM_RD = 22'h000004;
  localparam logic [21:0] C_MEM_WR = 22'h000008;
  localparam logic [21:0] C_MDR_IR = 22'h000010;
  localparam logic [21:0] C_PC_INC = 22'h000020;
  localparam logic [21:0] C_MDR_AC = 22'h000040;
  localparam logic [21:0] C_AC_MDR = 22'h000080;
  localparam logic [21:0] C_ALU_ADD = 22'h000100;
  localparam logic [21:0] C_IR_PC  = 22'h000200;

  logic [3:0]  state_q, state_d;
  logic [39:0] rom_word;
  logic        alpha, beta;

  function automatic logic [39:0] uword(input logic a_sel, input logic b_sel,
                                        input logic [3:0] a0, input logic [3:0] a1,
                                        input logic [3:0] a2, input logic [3:0] a3,
                                        input logic [21:0] ctrl);
    return {a_sel, b_sel, a0, a1, a2, a3, ctrl};
  endfunction

  // Leaf cells: out = sel ? in1 : in0, and out = i[{s1,s0}].
  function automatic logic multiplexer_2_1(input logic sel, input logic in0, input logic in1);
    return sel ? in1 : in0;
  endfunction

  function automatic logic [3:0] multiplexer_4_1(input logic s0, input logic s1,
                                                 input logic [3:0] i0, input logic [3:0] i1,
                                                 input logic [3:0] i2, input logic [3:0] i3);
    logic [3:0] o;
    case ({s1, s0})
      2'b00:   o = i0;
      2'b01:   o = i1;
      2'b10:   o = i2;
      default: o = i3;
    endcase
    return o;
  endfunction

  always_comb begin
    // NOTE: default first so every path assigns rom_word and no latch is inferred.
    rom_word = '0;
    case (state_q)
      4'd0:    rom_word = uword(1'b0, 1'b0, 4'd1,  4'd1,  4'd1,  4'd1,  C_PC_MAR);
      4'd1:    rom_word = uword(1'b0, 1'b0, 4'd2,  4'd2,  4'd1,  4'd1,  C_MEM_RD);
      4'd2:    rom_word = uword(1'b0, 1'b0, 4'd3,  4'd3,  4'd3,  4'd3,  C_MDR_IR | C_PC_INC);
      4'd3:    rom_word = uword(1'b1, 1'b1, 4'd4,  4'd7,  4'd9,  4'd12, '0);
      4'd4:    rom_word = uword(1'b0, 1'b0, 4'd5,  4'd5,  4'd5,  4'd5,  C_IR_MAR);
      4'd5:    rom_word = uword(1'b0, 1'b0, 4'd6,  4'd6,  4'd5,  4'd5,  C_MEM_RD);
      4'd6:    rom_word = uword(1'b0, 1'b0, 4'd0,  4'd0,  4'd0,  4'd0,  C_MDR_AC);
      4'd7:    rom_word = uword(1'b0, 1'b0, 4'd8,  4'd8,  4'd8,  4'd8,  C_IR_MAR | C_AC_MDR);
      4'd8:    rom_word = uword(1'b0, 1'b0, 4'd0,  4'd0,  4'd8,  4'd8,  C_MEM_WR);
      4'd9:    rom_word = uword(1'b0, 1'b0, 4'd10, 4'd10, 4'd10, 4'd10, C_IR_MAR);
      4'd10:   rom_word = uword(1'b0, 1'b0, 4'd11, 4'd11, 4'd10, 4'd10, C_MEM_RD);
      4'd11:   rom_word = uword(1'b0, 1'b0, 4'd0,  4'd0,  4'd0,  4'd0,  C_ALU_ADD);
      4'd12:   rom_word = uword(1'b1, 1'b0, 4'd0,  4'd13, 4'd0,  4'd13, '0);
      4'd13:   rom_word = uword(1'b0, 1'b0, 4'd0,  4'd0,  4'd0,  4'd0,  C_IR_PC);
      default: rom_word = uword(1'b0, 1'b0, 4'd0,  4'd0,  4'd0,  4'd0,  '0);
    endcase
  end

  always_comb begin
    alpha   = multiplexer_2_1(rom_word[39], wait_, IR15);
    beta    = multiplexer_2_1(rom_word[38], AC15, IR14);
    state_d = multiplexer_4_1(beta, alpha, rom_word[37:34], rom_word[33:30],
                              rom_word[29:26], rom_word[25:22]);
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignment for sequential state avoids simulation races.
    if (reset) state_q <= '0;
    else       state_q <= state_d;
  end

  assign bus_controller = rom_word[21:0];

`ifdef CTRL_DEBUG_EN
  assign state_dbg = state_q;
`endif

endmodule

// File: tb/tb_controller_rom.sv
// Directed self-checking bench for controller_rom; state is observed through bus_controller.
module tb_controller_rom;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wait_ = 1'b0;
  logic        IR15 = 1'b0;
  logic        IR14 = 1'b0;
  logic        AC15 = 1'b0;
  logic [21:0] bus_controller;
`ifdef CTRL_DEBUG_EN
  logic [3:0]  state_dbg;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  controller_rom dut (
    .clk            (clk),
    .reset          (reset),
    .wait_          (wait_),
    .IR15           (IR15),
    .IR14           (IR14),
    .AC15           (AC15),
`ifdef CTRL_DEBUG_EN
    .state_dbg      (state_dbg),
`endif
    .bus_controller (bus_controller)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the sequencer to fetch state 0 with a short asynchronous pulse.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    wait_ = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus_controller !== 22'h000001) begin
      errors++;
      $display("FAIL reset_async: got %h expected %h", bus_controller, 22'h000001);
    end
    tick();
    checks++;
    if (bus_controller !== 22'h000001) begin
      errors++;
      $display("FAIL reset_held: got %h expected %h", bus_controller, 22'h000001);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    checks++;
    if (bus_controller !== 22'h000004) begin
      errors++;
      $display("FAIL reset_release_to_1: got %h expected %h", bus_controller, 22'h000004);
    end
  endtask

  task automatic test_load();
    logic [21:0] e [8];
    e = '{22'h1, 22'h4, 22'h30, 22'h0, 22'h2, 22'h4, 22'h40, 22'h1};
    do_reset();
    {IR15, IR14} = 2'b00;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      checks++;
      if (bus_controller !== e[i]) begin
        errors++;
        $display("FAIL load_step%0d: got %h expected %h", i, bus_controller, e[i]);
      end
    end
  endtask

  task automatic test_wait_fetch();
    do_reset();
    {IR15, IR14} = 2'b00;
    wait_ = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      checks++;
      if (bus_controller !== 22'h000004) begin
        errors++;
        $display("FAIL wait_state1_cycle%0d: got %h expected %h", i, bus_controller, 22'h000004);
      end
    end
    wait_ = 1'b0;
    tick();
    checks++;
    if (bus_controller !== 22'h000030) begin
      errors++;
      $display("FAIL wait_leave_to_2: got %h expected %h", bus_controller, 22'h000030);
    end
  endtask

  task automatic test_store();
    logic [21:0] e [6];
    e = '{22'h1, 22'h4, 22'h30, 22'h0, 22'h82, 22'h8};
    do_reset();
    {IR15, IR14} = 2'b01;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      checks++;
      if (bus_controller !== e[i]) begin
        errors++;
        $display("FAIL store_step%0d: got %h expected %h", i, bus_controller, e[i]);
      end
    end
    wait_ = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus_controller !== 22'h000008) begin
        errors++;
        $display("FAIL store_hold8_%0d: got %h expected %h", i, bus_controller, 22'h000008);
      end
    end
    wait_ = 1'b0;
    tick();
    checks++;
    if (bus_controller !== 22'h000001) begin
      errors++;
      $display("FAIL store_return_0: got %h expected %h", bus_controller, 22'h000001);
    end
  endtask

  task automatic test_add();
    logic [21:0] e [8];
    e = '{22'h1, 22'h4, 22'h30, 22'h0, 22'h2, 22'h4, 22'h100, 22'h1};
    do_reset();
    {IR15, IR14} = 2'b10;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      checks++;
      if (bus_controller !== e[i]) begin
        errors++;
        $display("FAIL add_step%0d: got %h expected %h", i, bus_controller, e[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [21:0] t [7];
    logic [21:0] n [6];
    t = '{22'h1, 22'h4, 22'h30, 22'h0, 22'h0, 22'h200, 22'h1};
    n = '{22'h1, 22'h4, 22'h30, 22'h0, 22'h0, 22'h1};
    do_reset();
    {IR15, IR14} = 2'b11;
    AC15 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      checks++;
      if (bus_controller !== t[i]) begin
        errors++;
        $display("FAIL brn_taken_step%0d: got %h expected %h", i, bus_controller, t[i]);
      end
    end
    do_reset();
    AC15 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      checks++;
      if (bus_controller !== n[i]) begin
        errors++;
        $display("FAIL brn_not_taken_step%0d: got %h expected %h", i, bus_controller, n[i]);
      end
    end
  endtask

  // Counts cycles from fetch state 0 back to state 0; bounded so a stuck FSM still reports.
  task automatic test_cycle_counts();
    logic [1:0] ops   [5];
    logic       acs   [5];
    int         want  [5];
    int         cnt;
    ops  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
    acs  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    want = '{7, 6, 7, 6, 5};
    for (int k = 0; k < 5; k++) begin
      do_reset();
      {IR15, IR14} = ops[k];
      AC15 = acs[k];
      cnt = 0;
      do begin
        tick();
        cnt++;
      end while (bus_controller !== 22'h000001 && cnt < 30);
      checks++;
      if (cnt !== want[k]) begin
        errors++;
        $display("FAIL cycles_op%0d_ac%0d: got %0d expected %0d", ops[k], acs[k], cnt, want[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    {IR15, IR14} = 2'b01;
    AC15 = 1'b0;
    repeat (4) tick();
    checks++;
    if (bus_controller !== 22'h000082) begin
      errors++;
      $display("FAIL mid_reach_state7: got %h expected %h", bus_controller, 22'h000082);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus_controller !== 22'h000001) begin
      errors++;
      $display("FAIL mid_reset_async: got %h expected %h", bus_controller, 22'h000001);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    checks++;
    if (bus_controller !== 22'h000004) begin
      errors++;
      $display("FAIL mid_reset_then_1: got %h expected %h", bus_controller, 22'h000004);
    end
  endtask

`ifdef CTRL_DEBUG_EN
  task automatic test_debug_unused();
    do_reset();
    @(negedge clk);
    force dut.state_q = 4'd14;
    #1;
    release dut.state_q;
    checks++;
    if (state_dbg !== 4'd14 || bus_controller !== 22'h0) begin
      errors++;
      $display("FAIL dbg_state14: got %0d/%h expected 14/%h", state_dbg, bus_controller, 22'h0);
    end
    tick();
    checks++;
    if (state_dbg !== 4'd0 || bus_controller !== 22'h000001) begin
      errors++;
      $display("FAIL dbg_14_to_0: got %0d/%h expected 0/%h", state_dbg, bus_controller, 22'h000001);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_wait_fetch();
    test_store();
    test_add();
    test_branch();
    test_cycle_counts();
    test_reset_mid();
`ifdef CTRL_DEBUG_EN
    test_debug_unused();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
